// File: rtl/tick_watchdog_pkg.sv
// Shared timing definitions for the tick period chain: watchdog state encoding
// and default period/tolerance values also used by the upstream delay stage.
package tick_watchdog_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        FAULT  = 2'd3
    } wd_state_t;

    localparam int DEF_PERIOD = 7501;
    localparam int DEF_TOL    = 2;
    localparam int DEF_CBITS  = 14;
    localparam int DEF_DIV    = 4;
    localparam int DEF_MBITS  = 4;

endpackage

// File: rtl/tick_watchdog_interval_timer.sv
// Tick-to-tick interval counter with window classification of the current gap.
// Flags are combinational; the owning FSM decides which ones matter in each state.
module interval_timer #(
    parameter int PERIOD = 7501,
    parameter int TOL    = 2,
    parameter int CBITS  = 14
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic in_win,
    output logic early,
    output logic late
);

    localparam logic [CBITS-1:0] ICNT_ONE = CBITS'(1);
    localparam logic [CBITS:0]   GAP_ONE  = (CBITS+1)'(1);
    localparam logic [CBITS:0]   GAP_LO   = (CBITS+1)'(PERIOD - TOL);
    localparam logic [CBITS:0]   GAP_HI   = (CBITS+1)'(PERIOD + TOL);
    localparam logic [CBITS:0]   GAP_LATE = (CBITS+1)'(PERIOD + TOL + 1);

    logic [CBITS-1:0] icnt_reg;
    logic [CBITS:0]   gap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_reg <= '0;
        end else if (restart) begin
            icnt_reg <= '0;
        end else if (icnt_reg != '1) begin
            icnt_reg <= icnt_reg + ICNT_ONE;
        end
    end

    // One bit wider than the counter so the all-ones value cannot wrap to 0.
    assign gap    = {1'b0, icnt_reg} + GAP_ONE;
    assign in_win = (gap >= GAP_LO) && (gap <= GAP_HI);
    assign early  = (gap < GAP_LO);
    assign late   = (gap == GAP_LATE);

endmodule

// File: rtl/tick_watchdog.sv
// Checks the upstream tick period against a tolerance window, tracks lock,
// reports early/late faults with a saturating count, and emits a divided tick.
module tick_watchdog
    import tick_watchdog_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD,
    parameter int TOL    = DEF_TOL,
    parameter int CBITS  = DEF_CBITS,
    parameter int DIV    = DEF_DIV,
    parameter int MBITS  = DEF_MBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             up_err,
    input  logic             clear,
    output logic             lock,
    output logic             early_err,
    output logic             late_err,
    output logic             div_tick,
    output logic [MBITS-1:0] fault_cnt
);

    localparam int              DBITS    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DBITS-1:0] DCNT_TOP = DBITS'(DIV - 1);
    localparam logic [DBITS-1:0] DCNT_ONE = DBITS'(1);
    localparam logic [MBITS-1:0] FCNT_ONE = MBITS'(1);

    wd_state_t        state_reg, state_next;
    logic [DBITS-1:0] dcnt_reg, dcnt_next;
    logic [MBITS-1:0] fault_cnt_reg, fault_cnt_next;
    logic             lock_reg, early_reg, late_reg, div_reg;
    logic             early_next, late_next, div_next;
    logic             win_in, win_early, win_late;
    logic             restart;

    // Once faulted, ticks no longer restart the interval; only clear does.
    assign restart = clear || (tick && (state_reg != FAULT));

    interval_timer #(
        .PERIOD (PERIOD),
        .TOL    (TOL),
        .CBITS  (CBITS)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .in_win  (win_in),
        .early   (win_early),
        .late    (win_late)
    );

    always_comb begin
        state_next     = state_reg;
        dcnt_next      = dcnt_reg;
        fault_cnt_next = fault_cnt_reg;
        early_next     = 1'b0;
        late_next      = 1'b0;
        div_next       = 1'b0;

        if (clear) begin
            state_next = IDLE;
        end else if (up_err && (state_reg != FAULT)) begin
            state_next = FAULT;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        state_next = SYNC;
                    end
                end
                SYNC, LOCKED: begin
                    if (win_late) begin
                        late_next  = 1'b1;
                        state_next = FAULT;
                    end else if (tick && win_early) begin
                        early_next = 1'b1;
                        state_next = FAULT;
                    end else if (tick && win_in) begin
                        // First locked tick fires, then every DIV-th one after it.
                        state_next = LOCKED;
                        div_next   = (dcnt_reg == '0);
                        dcnt_next  = (dcnt_reg == DCNT_TOP) ? '0 : dcnt_reg + DCNT_ONE;
                    end
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        if (state_next != LOCKED) begin
            dcnt_next = '0;
        end

        if ((state_next == FAULT) && (state_reg != FAULT) && (fault_cnt_reg != '1)) begin
            fault_cnt_next = fault_cnt_reg + FCNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            dcnt_reg      <= '0;
            fault_cnt_reg <= '0;
            lock_reg      <= 1'b0;
            early_reg     <= 1'b0;
            late_reg      <= 1'b0;
            div_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dcnt_reg      <= dcnt_next;
            fault_cnt_reg <= fault_cnt_next;
            lock_reg      <= (state_next == LOCKED);
            early_reg     <= early_next;
            late_reg      <= late_next;
            div_reg       <= div_next;
        end
    end

    assign lock      = lock_reg;
    assign early_err = early_reg;
    assign late_err  = late_reg;
    assign div_tick  = div_reg;
    assign fault_cnt = fault_cnt_reg;

endmodule
